// File: rtl/linreg_pkg.sv
// rtl/linreg_pkg.sv - state encoding, derived widths and result fitting for linreg_coeff_unit
// COEFF_SAT_EN selects saturation instead of wrap when fitting coefficients.
package linreg_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PASS1 = 3'd1,
    MEAN  = 3'd2,
    PASS2 = 3'd3,
    DIV   = 3'd4,
    BETA0 = 3'd5,
    DONE  = 3'd6
  } state_t;

  function automatic int acc_w(input int data_w, input int log2_n);
    return data_w + log2_n;
  endfunction

  function automatic int dev_w(input int data_w);
    return data_w + 1;
  endfunction

  function automatic int sacc_w(input int data_w, input int log2_n);
    return 2 * dev_w(data_w) + log2_n;
  endfunction

  function automatic int num_w(input int data_w, input int frac_w, input int log2_n);
    return sacc_w(data_w, log2_n) + frac_w;
  endfunction

  // Result is sign-extended to 64 bits; callers keep the low w bits.
  function automatic logic signed [63:0] fit_data(input logic signed [63:0] v, input int w);
`ifdef COEFF_SAT_EN
    logic signed [63:0] v_max;
    logic signed [63:0] v_min;
    v_max = (64'sd1 <<< (w - 1)) - 64'sd1;
    v_min = -(64'sd1 <<< (w - 1));
    if (v > v_max)
      fit_data = v_max;
    else if (v < v_min)
      fit_data = v_min;
    else
      fit_data = v;
`else
    fit_data = (v <<< (64 - w)) >>> (64 - w);
`endif
  endfunction

endpackage

// File: rtl/linreg_seq_div.sv
// rtl/linreg_seq_div.sv - unsigned restoring divider, one quotient bit per cycle
// The start cycle already resolves the first quotient bit, so done follows NUM_W-1 cycles later.
module linreg_seq_div #(
  parameter int NUM_W = 16,
  parameter int DEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [NUM_W-1:0] i_num,
  input  logic [DEN_W-1:0] i_den,
  output logic             o_done,
  output logic [NUM_W-1:0] o_quot
);

  localparam int CNT_W = $clog2(NUM_W + 1);

  logic [DEN_W-1:0] r_rem;
  logic [DEN_W-1:0] r_den;
  logic [NUM_W-1:0] r_num;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  logic [DEN_W-1:0] w_rem_in;
  logic [DEN_W-1:0] w_den_in;
  logic [NUM_W-1:0] w_num_in;
  logic [DEN_W:0]   w_trial;
  logic [DEN_W:0]   w_diff;
  logic             w_ge;

  assign w_rem_in = i_start ? '0 : r_rem;
  assign w_den_in = i_start ? i_den : r_den;
  assign w_num_in = i_start ? i_num : r_num;
  assign w_trial  = {w_rem_in, w_num_in[NUM_W-1]};
  assign w_ge     = w_trial >= {1'b0, w_den_in};
  assign w_diff   = w_trial - {1'b0, w_den_in};

  // Numerator bits shift out the top while quotient bits shift in at the bottom.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem  <= '0;
      r_den  <= '0;
      r_num  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start || r_busy) begin
        r_rem <= DEN_W'(w_ge ? w_diff : w_trial);
        r_num <= {w_num_in[NUM_W-2:0], w_ge};
      end
      if (i_start) begin
        r_den  <= i_den;
        r_cnt  <= CNT_W'(NUM_W - 1);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_cnt <= r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done = r_done;
  assign o_quot = r_num;

endmodule

// File: rtl/linreg_coeff_unit.sv
// rtl/linreg_coeff_unit.sv - two-pass least-squares slope/intercept from streamed (x, y) pairs
// COEFF_SAT_EN (via linreg_pkg::fit_data) makes beta0/beta1 saturate instead of wrap.
module linreg_coeff_unit
  import linreg_pkg::*;
#(
  parameter int DATA_W = 20,
  parameter int FRAC_W = 10,
  parameter int LOG2_N = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_coe,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic signed [DATA_W-1:0] y_in,
  output logic                     mean_ready,
  output logic                     all_ready,
  output logic signed [DATA_W-1:0] beta0,
  output logic signed [DATA_W-1:0] beta1,
  output logic                     busy
);

  localparam int ACC_W  = acc_w(DATA_W, LOG2_N);
  localparam int DEV_W  = dev_w(DATA_W);
  localparam int SACC_W = sacc_w(DATA_W, LOG2_N);
  localparam int NUM_W  = num_w(DATA_W, FRAC_W, LOG2_N);
  localparam int N      = 1 << LOG2_N;
  localparam int CNT_W  = LOG2_N + 1;

  state_t                    r_state;
  logic        [CNT_W-1:0]   r_cnt;
  logic signed [ACC_W-1:0]   r_sx, r_sy;
  logic signed [DATA_W-1:0]  r_xm, r_ym;
  logic signed [SACC_W-1:0]  r_sxy, r_sxx;
  logic signed [DATA_W-1:0]  r_q;
  logic signed [DATA_W-1:0]  r_beta0, r_beta1;
  logic                      r_mean_ready, r_all_ready;

  logic                      w_accept;
  logic signed [ACC_W-1:0]   w_x_ext, w_y_ext;
  logic signed [DEV_W-1:0]   w_dx, w_dy;
  logic signed [2*DEV_W-1:0] w_dx2, w_dy2, w_pxy, w_pxx;
  logic signed [SACC_W-1:0]  w_pxy_ext, w_pxx_ext;
  logic        [SACC_W-1:0]  w_sxy_abs;
  logic        [NUM_W-1:0]   w_num, w_quot;
  logic                      w_div_start, w_div_done;
  logic signed [63:0]        w_q64, w_q_sgn, w_qx64, w_xm64, w_ym64, w_prod64, w_b0;

  assign w_accept = en_coe && sample_valid;
  assign w_x_ext  = {{LOG2_N{x_in[DATA_W-1]}}, x_in};
  assign w_y_ext  = {{LOG2_N{y_in[DATA_W-1]}}, y_in};

  assign w_dx      = {x_in[DATA_W-1], x_in} - {r_xm[DATA_W-1], r_xm};
  assign w_dy      = {y_in[DATA_W-1], y_in} - {r_ym[DATA_W-1], r_ym};
  assign w_dx2     = {{DEV_W{w_dx[DEV_W-1]}}, w_dx};
  assign w_dy2     = {{DEV_W{w_dy[DEV_W-1]}}, w_dy};
  assign w_pxy     = w_dx2 * w_dy2;
  assign w_pxx     = w_dx2 * w_dx2;
  assign w_pxy_ext = {{LOG2_N{w_pxy[2*DEV_W-1]}}, w_pxy};
  assign w_pxx_ext = {{LOG2_N{w_pxx[2*DEV_W-1]}}, w_pxx};

  // The divider works on magnitudes; the sign of Sxy is reapplied to the quotient.
  assign w_sxy_abs   = r_sxy[SACC_W-1] ? -r_sxy : r_sxy;
  assign w_num       = {w_sxy_abs, {FRAC_W{1'b0}}};
  assign w_div_start = (r_state == PASS2) && (r_cnt == CNT_W'(N)) && (r_sxx != '0);

  linreg_seq_div #(
    .NUM_W (NUM_W),
    .DEN_W (SACC_W)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_div_start),
    .i_num   (w_num),
    .i_den   (r_sxx),
    .o_done  (w_div_done),
    .o_quot  (w_quot)
  );

  assign w_q64    = {{(64-NUM_W){1'b0}}, w_quot};
  assign w_q_sgn  = r_sxy[SACC_W-1] ? -w_q64 : w_q64;
  assign w_qx64   = {{(64-DATA_W){r_q[DATA_W-1]}}, r_q};
  assign w_xm64   = {{(64-DATA_W){r_xm[DATA_W-1]}}, r_xm};
  assign w_ym64   = {{(64-DATA_W){r_ym[DATA_W-1]}}, r_ym};
  assign w_prod64 = w_qx64 * w_xm64;
  assign w_b0     = w_ym64 - (w_prod64 >>> FRAC_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_sx         <= '0;
      r_sy         <= '0;
      r_xm         <= '0;
      r_ym         <= '0;
      r_sxy        <= '0;
      r_sxx        <= '0;
      r_q          <= '0;
      r_beta0      <= '0;
      r_beta1      <= '0;
      r_mean_ready <= 1'b0;
      r_all_ready  <= 1'b0;
    end else begin
      r_mean_ready <= 1'b0;
      r_all_ready  <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_sx    <= w_x_ext;
            r_sy    <= w_y_ext;
            r_sxy   <= '0;
            r_sxx   <= '0;
            r_cnt   <= CNT_W'(1);
            r_state <= PASS1;
          end
        end
        PASS1: begin
          if (w_accept) begin
            r_sx  <= r_sx + w_x_ext;
            r_sy  <= r_sy + w_y_ext;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(N - 1))
              r_state <= MEAN;
          end
        end
        MEAN: begin
          // Top DATA_W bits of the sum are the floor of sum / N.
          r_xm         <= r_sx[LOG2_N +: DATA_W];
          r_ym         <= r_sy[LOG2_N +: DATA_W];
          r_mean_ready <= 1'b1;
          r_cnt        <= '0;
          r_state      <= PASS2;
        end
        PASS2: begin
          if (r_cnt == CNT_W'(N)) begin
            if (r_sxx == '0) begin
              r_q     <= '0;
              r_state <= BETA0;
            end else begin
              r_state <= DIV;
            end
          end else if (w_accept) begin
            r_sxy <= r_sxy + w_pxy_ext;
            r_sxx <= r_sxx + w_pxx_ext;
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DIV: begin
          if (w_div_done) begin
            r_q     <= DATA_W'(fit_data(w_q_sgn, DATA_W));
            r_state <= BETA0;
          end
        end
        BETA0: begin
          r_beta1     <= r_q;
          r_beta0     <= DATA_W'(fit_data(w_b0, DATA_W));
          r_all_ready <= 1'b1;
          r_state     <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mean_ready = r_mean_ready;
  assign all_ready  = r_all_ready;
  assign beta0      = r_beta0;
  assign beta1      = r_beta1;
  assign busy       = (r_state != IDLE) && (r_state != DONE);

endmodule
